// File: rtl/mem_port_arbiter_pkg.sv
// Shared core definitions used by the RAM port arbiter.
// Provides the instruction_type enum, the 32-bit word type, the RAM size,
// the arbiter ownership enum and load/store classification helpers.
package mem_port_arbiter_pkg;

    typedef logic [31:0] wires32;

    localparam int unsigned MEMORY_SIZE = 131072;

    typedef enum logic [4:0] {
        ADD, SUB, SLL, SLT, SLTU, SRL, SRA,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        BEQ, BNE, JAL, JALR, LUI, AUIPC
    } instruction_type;

    // Who owns the RAM port in a given cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } mem_owner;

    function automatic logic is_load(instruction_type op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_store(instruction_type op);
        return op inside {SB, SH, SW};
    endfunction

    // Alignment check only; range and op legality are checked separately.
    function automatic logic is_misaligned(instruction_type op, logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = op inside {LH, LHU, SH};
        word_op = op inside {LW, SW};
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_port_arbiter_load_align.sv
// Load alignment: selects the byte/half addressed by off_i from a RAM word
// and sign- or zero-extends it according to op_i. LW passes the word through
// (also used for instruction fetch). Any non-load op yields 0.
//   rdata_i  - raw RAM read word
//   op_i     - access type captured at grant time
//   off_i    - byte offset within the word (addr[1:0])
//   result_o - extended load result
module mem_port_arbiter_load_align
    import mem_port_arbiter_pkg::*;
(
    input  wires32          rdata_i,
    input  instruction_type op_i,
    input  logic [1:0]      off_i,
    output wires32          result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        result_o = '0;
        case (op_i)
            LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result_o = {24'b0, byte_sel};
            LH:      result_o = {{16{half_sel[15]}}, half_sel};
            LHU:     result_o = {16'b0, half_sel};
            LW:      result_o = rdata_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared between instruction fetch and the load/store unit.
// Data has priority; fetch is forced through after STARVE_LIMIT lost cycles.
// Illegal requests (misaligned, out of range, non-memory op) are granted but
// never reach the RAM; they get an error response one cycle later.
//   clk, rstn                        - clock, async active-low reset
//   i_req/i_addr/i_gnt               - fetch request channel
//   i_rvalid/i_rdata/i_err           - fetch response (cycle after grant)
//   d_req/d_op/d_addr/d_wdata/d_gnt  - data request channel
//   d_rvalid/d_rdata/d_err           - data response (cycle after grant)
//   mem_en/mem_we/mem_addr/mem_wdata - RAM request, mem_rdata one cycle later
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MEM_BYTES    = MEMORY_SIZE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [4:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRespI, StRespD} state_e;

    instruction_type d_op_e;
    logic            fetch_forced;
    logic            i_ill;
    logic            d_ill;
    mem_owner        owner;
    logic [2:0]      starve_q, starve_d;

    state_e          state_q;
    instruction_type op_q;
    logic [1:0]      off_q;
    logic            err_q;
    wires32          align_data;

    assign d_op_e       = instruction_type'(d_op);
    assign fetch_forced = (starve_q == 3'(STARVE_LIMIT));

    // Grants are gated by rstn so nothing is accepted while in reset.
    assign i_gnt = rstn & i_req & (~d_req | fetch_forced);
    assign d_gnt = rstn & d_req & ~(i_req & fetch_forced);

    assign i_ill = (i_addr[1:0] != 2'b00) || (i_addr >= 32'(MEM_BYTES));
    assign d_ill = !(is_load(d_op_e) || is_store(d_op_e))
                 || is_misaligned(d_op_e, d_addr[1:0])
                 || (d_addr >= 32'(MEM_BYTES));

    always_comb begin
        if (i_gnt) begin
            owner = OWN_I;
        end else if (d_gnt) begin
            owner = OWN_D;
        end else begin
            owner = OWN_NONE;
        end
    end

    // RAM request; all zero unless a legal access is granted this cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (owner == OWN_I && !i_ill) begin
            mem_en   = 1'b1;
            mem_addr = {i_addr[31:2], 2'b00};
        end else if (owner == OWN_D && !d_ill) begin
            mem_en   = 1'b1;
            mem_addr = {d_addr[31:2], 2'b00};
            case (d_op_e)
                SB: begin
                    mem_we    = 4'b0001 << d_addr[1:0];
                    mem_wdata = {4{d_wdata[7:0]}};
                end
                SH: begin
                    mem_we    = 4'b0011 << d_addr[1:0];
                    mem_wdata = {2{d_wdata[15:0]}};
                end
                SW: begin
                    mem_we    = 4'b1111;
                    mem_wdata = d_wdata;
                end
                default: ;
            endcase
        end
    end

    // Saturating count of consecutive cycles fetch waited while requesting.
    always_comb begin
        if (!i_req || i_gnt) begin
            starve_d = '0;
        end else if (starve_q != 3'd7) begin
            starve_d = starve_q + 3'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Response FSM: remembers what was granted so the next cycle can return it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            op_q    <= LW;
            off_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            case (owner)
                OWN_I: begin
                    state_q <= StRespI;
                    op_q    <= LW;
                    off_q   <= 2'b00;
                    err_q   <= i_ill;
                end
                OWN_D: begin
                    state_q <= StRespD;
                    op_q    <= d_op_e;
                    off_q   <= d_addr[1:0];
                    err_q   <= d_ill;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    mem_port_arbiter_load_align u_load_align (
        .rdata_i  (mem_rdata),
        .op_i     (op_q),
        .off_i    (off_q),
        .result_o (align_data)
    );

    assign i_rvalid = (state_q == StRespI);
    assign i_err    = i_rvalid & err_q;
    assign i_rdata  = (i_rvalid && !err_q) ? align_data : '0;

    assign d_rvalid = (state_q == StRespD);
    assign d_err    = d_rvalid & err_q;
    assign d_rdata  = (d_rvalid && !err_q) ? align_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned MEM_BYTES    = 131072;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [4:0]  d_op;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .MEM_BYTES    (MEM_BYTES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_op      (d_op),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct packed {
        logic        i_gnt;
        logic        i_rvalid;
        logic        i_err;
        logic [31:0] i_rdata;
        logic        d_gnt;
        logic        d_rvalid;
        logic        d_err;
        logic [31:0] d_rdata;
        logic        mem_en;
        logic [3:0]  mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } outs_t;

    // Reference model state: starvation count and the one outstanding response.
    int          m_starve = 0;
    bit          p_valid  = 0;
    bit          p_is_i   = 0;
    bit          p_err    = 0;
    logic [4:0]  p_op     = 5'd0;
    logic [1:0]  p_off    = 2'd0;

    function automatic int unsigned op_size(logic [4:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit op_is_store(logic [4:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic bit d_legal(logic [4:0] op, logic [31:0] addr);
        int unsigned sz;
        sz = op_size(op);
        if (sz == 0) return 0;
        return (addr % sz == 0) && (addr < MEM_BYTES);
    endfunction

    function automatic bit i_legal(logic [31:0] addr);
        return (addr % 4 == 0) && (addr < MEM_BYTES);
    endfunction

    function automatic logic [31:0] expect_load(logic [4:0] op, logic [1:0] off,
                                                logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd >> (8 * off);
        case (op)
            LB:  begin v = sh & 32'hFF;   if (v >= 128)   v = v - 256;   end
            LBU: v = sh & 32'hFF;
            LH:  begin v = sh & 32'hFFFF; if (v >= 32768) v = v - 65536; end
            LHU: v = sh & 32'hFFFF;
            LW:  v = rd;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic bit fetch_wins();
        return i_req && (!d_req || m_starve == STARVE_LIMIT);
    endfunction

    function automatic outs_t model_exp();
        outs_t e;
        bit fw, dw;
        int unsigned sz;
        e = '0;
        if (rstn) begin
            fw = fetch_wins();
            dw = d_req && !fw;
            e.i_gnt = fw;
            e.d_gnt = dw;
            if (fw && i_legal(i_addr)) begin
                e.mem_en   = 1;
                e.mem_addr = i_addr - (i_addr % 4);
            end else if (dw && d_legal(d_op, d_addr)) begin
                e.mem_en   = 1;
                e.mem_addr = d_addr - (d_addr % 4);
                if (op_is_store(d_op)) begin
                    sz = op_size(d_op);
                    e.mem_we = 4'(((1 << sz) - 1) << (d_addr % 4));
                    if (sz == 1)      e.mem_wdata = (d_wdata & 32'hFF) * 32'h01010101;
                    else if (sz == 2) e.mem_wdata = (d_wdata & 32'hFFFF) * 32'h00010001;
                    else              e.mem_wdata = d_wdata;
                end
            end
            if (p_valid) begin
                if (p_is_i) begin
                    e.i_rvalid = 1;
                    e.i_err    = p_err;
                    e.i_rdata  = p_err ? 32'h0 : mem_rdata;
                end else begin
                    e.d_rvalid = 1;
                    e.d_err    = p_err;
                    e.d_rdata  = p_err ? 32'h0 : expect_load(p_op, p_off, mem_rdata);
                end
            end
        end
        return e;
    endfunction

    function automatic outs_t get_obs();
        outs_t o;
        o.i_gnt     = i_gnt;
        o.i_rvalid  = i_rvalid;
        o.i_err     = i_err;
        o.i_rdata   = i_rdata;
        o.d_gnt     = d_gnt;
        o.d_rvalid  = d_rvalid;
        o.d_err     = d_err;
        o.d_rdata   = d_rdata;
        o.mem_en    = mem_en;
        o.mem_we    = mem_we;
        o.mem_addr  = mem_addr;
        o.mem_wdata = mem_wdata;
        return o;
    endfunction

    // Advance one clock; the model updates from the inputs seen at the edge.
    task automatic tick();
        bit fw, dw;
        @(posedge clk);
        if (!rstn) begin
            m_starve = 0;
            p_valid  = 0;
        end else begin
            fw = fetch_wins();
            dw = d_req && !fw;
            p_valid = fw || dw;
            p_is_i  = fw;
            if (fw) begin
                p_err = !i_legal(i_addr);
                p_op  = LW;
                p_off = 2'd0;
            end else if (dw) begin
                p_err = !d_legal(d_op, d_addr);
                p_op  = d_op;
                p_off = 2'(d_addr % 4);
            end
            if (!i_req || fw) m_starve = 0;
            else if (m_starve < 7) m_starve = m_starve + 1;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_addr(bit word_bias);
        int unsigned r;
        logic [31:0] a;
        r = $urandom_range(0, 15);
        if (r == 0)      a = 32'h1FFFC + 32'($urandom_range(0, 7));
        else if (r == 1) a = $urandom;
        else             a = 32'($urandom_range(0, 255));
        if (word_bias && r > 2) a = a & ~32'h3;
        return a;
    endfunction

    task automatic test_reset();
        outs_t o;
        rstn = 0; i_req = 1; d_req = 1; d_op = LW;
        i_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h1234_5678; mem_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            o = get_obs();
            n_total++;
            if (o !== outs_t'(0))
                $display("FAIL reset_outputs cycle %0d: got %h want 0", k, o);
            else n_pass++;
            tick();
        end
        i_req = 0; d_req = 0;
        rstn = 1;
    endtask

    task automatic test_fetch_stream();
        outs_t o, e;
        d_req = 0;
        for (int k = 0; k < 4; k++) begin
            i_req = (k < 3);
            i_addr = 32'(4 * k);
            mem_rdata = 32'h0000_0013;
            @(negedge clk);
            o = get_obs(); e = model_exp();
            n_total++;
            if (o !== e) $display("FAIL fetch_model k=%0d: got %h want %h", k, o, e);
            else n_pass++;
            if (k < 3) begin
                n_total++;
                if ({o.i_gnt, o.mem_en, o.mem_addr} !== {1'b1, 1'b1, 32'(4 * k)})
                    $display("FAIL fetch_grant k=%0d: got %b %b %h want 1 1 %h",
                             k, o.i_gnt, o.mem_en, o.mem_addr, 32'(4 * k));
                else n_pass++;
            end
            if (k > 0) begin
                n_total++;
                if ({o.i_rvalid, o.i_err, o.i_rdata} !== {1'b1, 1'b0, 32'h13})
                    $display("FAIL fetch_resp k=%0d: got %b %b %h want 1 0 00000013",
                             k, o.i_rvalid, o.i_err, o.i_rdata);
                else n_pass++;
            end
            tick();
        end
        i_req = 0;
    endtask

    task automatic test_store_load();
        outs_t o;
        i_req = 0;
        d_req = 1; d_op = SB; d_addr = 32'h102; d_wdata = 32'h0000_00AB; mem_rdata = 32'h0;
        @(negedge clk);
        o = get_obs();
        n_total++;
        if ({o.d_gnt, o.mem_en, o.mem_we, o.mem_addr, o.mem_wdata} !==
            {1'b1, 1'b1, 4'b0100, 32'h100, 32'hABABABAB})
            $display("FAIL sb_request: got %b %b %b %h %h want 1 1 0100 00000100 abababab",
                     o.d_gnt, o.mem_en, o.mem_we, o.mem_addr, o.mem_wdata);
        else n_pass++;
        tick();
        d_op = LB; d_addr = 32'h102;
        @(negedge clk);
        o = get_obs();
        n_total++;
        if ({o.d_rvalid, o.d_err, o.d_rdata, o.mem_we, o.mem_addr} !==
            {1'b1, 1'b0, 32'h0, 4'b0000, 32'h100})
            $display("FAIL sb_resp_lb_req: got %b %b %h %b %h want 1 0 0 0000 00000100",
                     o.d_rvalid, o.d_err, o.d_rdata, o.mem_we, o.mem_addr);
        else n_pass++;
        tick();
        d_op = LBU; mem_rdata = 32'h00AB_0000;
        @(negedge clk);
        o = get_obs();
        n_total++;
        if ({o.d_rvalid, o.d_rdata} !== {1'b1, 32'hFFFF_FFAB})
            $display("FAIL lb_sign_ext: got %b %h want 1 ffffffab", o.d_rvalid, o.d_rdata);
        else n_pass++;
        tick();
        d_req = 0;
        @(negedge clk);
        o = get_obs();
        n_total++;
        if ({o.d_rvalid, o.d_rdata} !== {1'b1, 32'h0000_00AB})
            $display("FAIL lbu_zero_ext: got %b %h want 1 000000ab", o.d_rvalid, o.d_rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_illegal();
        logic [4:0]  ops   [4] = '{LH, SW, LW, ADD};
        logic [31:0] addrs [4] = '{32'h101, 32'h102, 32'h20000, 32'h100};
        outs_t o;
        i_req = 0;
        for (int k = 0; k < 4; k++) begin
            d_req = 1; d_op = ops[k]; d_addr = addrs[k]; d_wdata = $urandom;
            @(negedge clk);
            o = get_obs();
            n_total++;
            if ({o.d_gnt, o.mem_en, o.mem_we, o.mem_addr, o.mem_wdata} !== {1'b1, 69'b0})
                $display("FAIL illegal_req k=%0d: got gnt=%b en=%b we=%b addr=%h wd=%h",
                         k, o.d_gnt, o.mem_en, o.mem_we, o.mem_addr, o.mem_wdata);
            else n_pass++;
            tick();
            d_req = 0; mem_rdata = $urandom | 32'h1;
            @(negedge clk);
            o = get_obs();
            n_total++;
            if ({o.d_rvalid, o.d_err, o.d_rdata} !== {1'b1, 1'b1, 32'h0})
                $display("FAIL illegal_resp k=%0d: got %b %b %h want 1 1 0",
                         k, o.d_rvalid, o.d_err, o.d_rdata);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_starvation();
        outs_t o, e;
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_op = LW; d_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            mem_rdata = $urandom;
            @(negedge clk);
            o = get_obs(); e = model_exp();
            n_total++;
            if ({o.i_gnt, o.d_gnt} !== {(k % 5 == 4), (k % 5 != 4)})
                $display("FAIL starve_pattern k=%0d: got i=%b d=%b", k, o.i_gnt, o.d_gnt);
            else n_pass++;
            n_total++;
            if (o !== e) $display("FAIL starve_model k=%0d: got %h want %h", k, o, e);
            else n_pass++;
            tick();
        end
        i_req = 0; d_req = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        outs_t o;
        i_req = 0;
        d_req = 1; d_op = LW; d_addr = 32'h10; mem_rdata = 32'h0;
        @(negedge clk);
        n_total++;
        if ({d_gnt, mem_en} !== 2'b11) $display("FAIL rst_mid_grant: got %b%b want 11", d_gnt, mem_en);
        else n_pass++;
        tick();
        rstn = 0; i_req = 1; d_req = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        o = get_obs();
        n_total++;
        if (o !== outs_t'(0)) $display("FAIL rst_mid_outputs: got %h want 0", o);
        else n_pass++;
        tick();
        rstn = 1; i_req = 0; d_req = 0;
        @(negedge clk);
        n_total++;
        if ({d_rvalid, i_rvalid} !== 2'b00) $display("FAIL rst_mid_dropped: got %b%b want 00", d_rvalid, i_rvalid);
        else n_pass++;
        tick();
        d_req = 1; d_op = LW; d_addr = 32'h20;
        @(negedge clk);
        n_total++;
        if ({d_gnt, mem_en, mem_addr} !== {2'b11, 32'h20})
            $display("FAIL rst_mid_regrant: got %b%b %h want 11 00000020", d_gnt, mem_en, mem_addr);
        else n_pass++;
        tick();
        d_req = 0; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        n_total++;
        if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h1357_9BDF})
            $display("FAIL rst_mid_resp: got %b%b %h want 10 13579bdf", d_rvalid, d_err, d_rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [4:0] ops [9] = '{LB, LBU, LH, LHU, LW, SB, SH, SW, ADD};
        outs_t o, e;
        bit i_hold = 0, d_hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (!i_hold) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = rand_addr(1);
            end
            if (!d_hold) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_op    = ops[$urandom_range(0, 8)];
                d_addr  = rand_addr(0);
                d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            @(negedge clk);
            o = get_obs(); e = model_exp();
            n_total++;
            if (o !== e) $display("FAIL random n=%0d: got %h want %h", n, o, e);
            else n_pass++;
            i_hold = i_req && !e.i_gnt;
            d_hold = d_req && !e.d_gnt;
            tick();
        end
        i_req = 0; d_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_store_load();
        test_illegal();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
